instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Assembler-side counterpart of the lab CPU instruction decoder.
- Accepts instruction fields (opcode, register numbers, signed immediate) over a valid/ready handshake and packs them into 16-bit instruction words in the decoder's formats.
- Buffers encoded words in a small FIFO and streams them sequentially into instruction memory.
- Range-checks every field; illegal instructions are dropped and reported.

Parameters:
ADDR_W, 8, instruction-memory address width; capacity is 2^ADDR_W words.
FIFO_DEPTH, 4, encoded-word buffer depth; power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
load_start  in  1  one-cycle pulse: restart loading at address 0 and clear errors.
in_valid  in  1  instruction fields valid.
in_ready  out  1  encoder can accept fields this cycle.
in_opcode  in  4  opcode.
in_rd  in  3  destination register.
in_rs  in  3  source/base register.
in_rt  in  3  second source / store-data register.
in_imm  in  16  signed immediate, nzimm or branch offset.
imem_we  out  1  instruction-memory write strobe.
imem_addr  out  ADDR_W  write address.
imem_wdata  out  16  encoded instruction word.
mem_full  out  1  last address written; further input is refused.
instr_count  out  ADDR_W+1  number of words written since reset or load_start.
err_valid  out  1  sticky: at least one instruction was rejected.
err_code  out  2  first error: 0 = bad opcode, 1 = immediate out of range, 2 = zero nzimm, 3 = base register above r3.

Behaviour:
- Reset: all outputs 0, except in_ready, which is 1 when reset deasserts. FIFO is empty and the address counter is 0.
- Word formats (opcode is always in [15:12]):
  - I7, opcodes 0000, 0001, 0101: rt in [11:9], rs[1:0] in [8:7], imm[6:0] in [6:0]. Immediate range is -64..63. rs must be at most 3.
  - R, opcodes 0010, 0100, 0110, 0111: rd in [11:9], rs in [8:6], rt in [5:3], and [2:0] = 000.
  - N6, opcodes 0011, 1000, 1001: rd in [11:9], rs in [8:6], nzimm in [5:0]. Immediate range is -32..31 and must be nonzero.
  - B9, opcodes 1010, 1011: rs in [11:9], offset in [8:0]. Immediate range is -256..255.
  - Opcodes 1100 to 1111 are illegal.
- Range checks treat in_imm as signed 16-bit. Truncation is to the low bits, two's complement.
- Accept happens when in_valid and in_ready are both high at a rising edge. Encoding is combinational on the inputs.
  - A legal word is pushed into the FIFO on the accept edge.
  - An illegal word is not pushed. err_valid is set on the accept edge. err_code is latched only if err_valid was previously 0, so the first error wins.
  - The check order for err_code is opcode, then base register, then zero nzimm, then range.
- in_ready = FIFO not full AND not mem_full AND not load_start.
- Drain: whenever the FIFO is non-empty and mem_full is 0:
  - imem_we = 1, imem_wdata = FIFO head, imem_addr = current counter.
  - At the edge, pop the head, increment the address, and increment instr_count.
  - Latency from accept edge to imem_we high is 1 cycle when the FIFO was empty.
- Push and pop may occur in the same cycle. Occupancy is then unchanged. A full FIFO accepts nothing that cycle, even if a pop occurs.
- Wrap/full: the write to address 2^ADDR_W-1 sets mem_full at that edge. The counter does not wrap. Remaining FIFO entries are discarded. instr_count saturates at 2^ADDR_W.
- load_start (synchronous):
  - Flush the FIFO.
  - Set the address and instr_count to 0.
  - Clear mem_full, err_valid and err_code.
  - imem_we is forced to 0 during the pulse cycle.
  - An input handshake is not possible in that cycle.
- Asynchronous reset mid-stream aborts immediately. No further writes occur until new input arrives.

Test Plan:
- Opcode 0000, rt=2, rs=1, imm=-3 -> imem_wdata 0x04FD at addr 0, imem_we one cycle after accept, instr_count=1.
- Back-to-back: R-type 0100 (rd=1, rs=2, rt=3), then B9 1011 (rs=5, offset=-1), then N6 1000 (rd=7, rs=0, imm=31) -> 0x4298, 0xBBFF, 0x8E1F at addresses 0, 1, 2 on consecutive cycles.
- Errors: opcode 1101 -> err_valid=1, err_code=0, no write. Then I7 with imm=64 -> no write, and err_code stays 0. Then N6 with imm=0 -> no write.
- I7 with rs=4 -> err_code=3 if it is the first error.
- With ADDR_W=2, stream 6 legal words:
  - Writes occur at addresses 0 to 3; mem_full=1 after the fourth write.
  - in_ready=0 from then on; instr_count=4; remaining entries are discarded.
  - A load_start pulse clears mem_full and the next word is written at addr 0.
- Hold in_valid high with imem writes active and check that in_ready never drops with FIFO_DEPTH=4. Then assert rst_n=0 mid-stream -> imem_we goes to 0 immediately and the FIFO is empty after release.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Assembler-side partner of the lab CPU instruction decoder. Instruction
//   fields arrive over a valid/ready handshake. Each instruction is
//   range-checked, packed into a 16-bit word in the decoder's format, buffered
//   in a small FIFO and then written to instruction memory one word per cycle
//   at consecutive addresses. Illegal instructions are dropped, and the first
//   error seen is kept in err_code.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   load_start        one-cycle pulse: flush, restart at address 0, clear errors
//   in_valid/in_ready input handshake for the instruction fields
//   in_opcode/in_rd/in_rs/in_rt/in_imm  instruction fields (in_imm is signed)
//   imem_we/imem_addr/imem_wdata        instruction-memory write port
//   mem_full          the last memory address has been written
//   instr_count       words written since reset or load_start
//   err_valid/err_code sticky error flag and the code of the first error
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              mem_full,
  output logic [ADDR_W:0]   instr_count,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [1:0] ERR_OPCODE = 2'd0;
  localparam logic [1:0] ERR_RANGE  = 2'd1;
  localparam logic [1:0] ERR_ZERO   = 2'd2;
  localparam logic [1:0] ERR_BASE   = 2'd3;

  logic [15:0]       word;
  logic              legal;
  logic [1:0]        code;
  logic              fits7, fits6, fits9;

  logic [15:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   icount_q, icount_d;
  logic              mem_full_q, mem_full_d;
  logic              err_valid_q;
  logic [1:0]        err_code_q;

  logic              fifo_full;
  logic              accept, push, pop;

  // A signed value fits in N bits exactly when every bit from N-1 upward
  // equals the sign bit, i.e. that upper slice is all zeros or all ones.
  assign fits7 = (&in_imm[15:6]) | ~(|in_imm[15:6]);
  assign fits6 = (&in_imm[15:5]) | ~(|in_imm[15:5]);
  assign fits9 = (&in_imm[15:8]) | ~(|in_imm[15:8]);

  // Pack the fields and classify the instruction. The if/else chains give
  // the error priority: opcode, then base register, then zero nzimm, then range.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    code  = ERR_OPCODE;
    case (in_opcode)
      4'b0000, 4'b0001, 4'b0101: begin
        word = {in_opcode, in_rt, in_rs[1:0], in_imm[6:0]};
        if (in_rs[2])    code  = ERR_BASE;
        else if (!fits7) code  = ERR_RANGE;
        else             legal = 1'b1;
      end
      4'b0010, 4'b0100, 4'b0110, 4'b0111: begin
        word  = {in_opcode, in_rd, in_rs, in_rt, 3'b000};
        legal = 1'b1;
      end
      4'b0011, 4'b1000, 4'b1001: begin
        word = {in_opcode, in_rd, in_rs, in_imm[5:0]};
        if (in_imm == 16'd0) code  = ERR_ZERO;
        else if (!fits6)     code  = ERR_RANGE;
        else                 legal = 1'b1;
      end
      4'b1010, 4'b1011: begin
        word = {in_opcode, in_rs, in_imm[8:0]};
        if (!fits9) code  = ERR_RANGE;
        else        legal = 1'b1;
      end
      default: begin
        code  = ERR_OPCODE;
        legal = 1'b0;
      end
    endcase
  end

  assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign in_ready  = !fifo_full && !mem_full_q && !load_start;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = (cnt_q != '0) && !mem_full_q && !load_start;

  assign imem_we     = pop;
  assign imem_addr   = addr_q;
  assign imem_wdata  = fifo_q[rd_ptr_q];
  assign mem_full    = mem_full_q;
  assign instr_count = icount_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;

  // Next-state for the FIFO pointers and the memory write counter. Writing
  // the last address freezes the counter and throws away anything still
  // buffered, including a word pushed on that same edge.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    icount_d   = icount_q;
    mem_full_d = mem_full_q;
    if (load_start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      addr_d     = '0;
      icount_d   = '0;
      mem_full_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      if (pop) begin
        icount_d = icount_q + (ADDR_W+1)'(1);
        if (addr_q == LAST_ADDR) begin
          mem_full_d = 1'b1;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          cnt_d      = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // Control state; reset leaves the FIFO empty so no write can follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      icount_q   <= '0;
      mem_full_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      icount_q   <= icount_d;
      mem_full_q <= mem_full_d;
    end
  end

  // Word storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= word;
  end

  // Sticky error flag; only the first rejected instruction sets the code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else if (load_start) begin
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else if (accept && !legal) begin
      err_valid_q <= 1'b1;
      if (!err_valid_q) err_code_q <= code;
    end
  end

endmodule
